bit_serial_adder: RTL and testbench

- Multi-cycle WIDTH-bit adder built around one half-adder-pair full-adder cell and a carry flip-flop.
- Adds one bit pair per clock, LSB first, and presents a registered Sum/Carry with a start/busy/done handshake.
- Sits directly downstream of the combinational half-adder cell, chaining it over time to form word-level addition for the lab datapath.

---
 rtl/bit_serial_adder.sv | 116 +++++++++++
 tb/tb_bit_serial_adder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one full-adder cell plus a carry flop, one bit pair per clock, LSB first.
// Optional BIT_SERIAL_ADDER_SUB_EN adds a sub port for A-B via two's complement of B.
module bit_serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef BIT_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] ra, ra_d;
    logic [WIDTH-1:0] rb, rb_d;
    logic [WIDTH-1:0] rs, rs_d;
    logic             c, c_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [WIDTH-1:0] sum_d;
    logic             carry_d;
    logic             done_d;
    logic             busy_d;
    logic             s;
    logic             co;
    logic             sub_in;

`ifdef BIT_SERIAL_ADDER_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    // State and datapath registers; reset clears everything, aborting any run silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            rs    <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            Sum   <= '0;
            Carry <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_d;
            ra    <= ra_d;
            rb    <= rb_d;
            rs    <= rs_d;
            c     <= c_d;
            cnt   <= cnt_d;
            Sum   <= sum_d;
            Carry <= carry_d;
            done  <= done_d;
            busy  <= busy_d;
        end
    end

    // Next-state, full-adder cell and output staging.
    always_comb begin
        state_d = state;
        ra_d    = ra;
        rb_d    = rb;
        rs_d    = rs;
        c_d     = c;
        cnt_d   = cnt;
        sum_d   = Sum;
        carry_d = Carry;
        done_d  = 1'b0;
        s       = ra[0] ^ rb[0] ^ c;
        co      = (ra[0] & rb[0]) | (c & (ra[0] ^ rb[0]));

        case (state)
            IDLE: begin
                if (start) begin
                    ra_d    = A;
                    rb_d    = sub_in ? ~B : B;
                    c_d     = sub_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                ra_d  = ra >> 1;
                rb_d  = rb >> 1;
                rs_d  = WIDTH'({s, rs} >> 1);
                c_d   = co;
                cnt_d = cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) begin
                    sum_d   = rs_d;
                    carry_d = co;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase

        busy_d = (state_d == RUN);
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Bench for bit_serial_adder: directed scenarios with literal expectations plus random traffic
// checked every cycle against a word-level arithmetic model.
module tb_bit_serial_adder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_o;
    logic         carry_o;

    int tests = 0;
    int fails = 0;

    // Reference model state: cycles left in the current operation and the expected registered outputs.
    int           remaining = 0;
    logic [W-1:0] pend_sum  = '0;
    logic         pend_carry = 1'b0;
    logic [W-1:0] m_sum     = '0;
    logic         m_carry   = 1'b0;
    logic         m_done    = 1'b0;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (a),
        .B     (b),
`ifdef BIT_SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .Sum   (sum_o),
        .Carry (carry_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level reference: plain addition or subtraction of the captured operands.
    task automatic model_edge();
        logic [W:0] full;
        if (reset) begin
            remaining = 0;
            m_sum     = '0;
            m_carry   = 1'b0;
            m_done    = 1'b0;
        end else begin
            m_done = 1'b0;
            if (remaining == 0) begin
                if (start) begin
                    remaining = W;
                    if (sub) begin
                        pend_sum   = a - b;
                        pend_carry = (a >= b);
                    end else begin
                        full       = {1'b0, a} + {1'b0, b};
                        pend_sum   = full[W-1:0];
                        pend_carry = full[W];
                    end
                end
            end else begin
                remaining--;
                if (remaining == 0) begin
                    m_sum   = pend_sum;
                    m_carry = pend_carry;
                    m_done  = 1'b1;
                end
            end
        end
    endtask

    // One clock: advance the model at the edge, compare all outputs 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("busy",  32'(busy),    32'(remaining > 0));
        check("done",  32'(done),    32'(m_done));
        check("sum",   32'(sum_o),   32'(m_sum));
        check("carry", 32'(carry_o), 32'(m_carry));
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          output int busy_cycles, output bit got_done);
        start = 1'b1; a = x; b = y; sub = s;
        busy_cycles = 0;
        got_done = 1'b0;
        cycle();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            cycle();
        end
        check("done_seen", 32'(got_done), 32'd1);
    endtask

    initial begin
        int  bc;
        bit  gd;
        int  ndone;
        int  gap;

        reset = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
        cycle();
        cycle();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum",  32'(sum_o), 32'd0);
        reset = 1'b0;
        cycle();

        // 0x00 + 0x00
        run_op(8'h00, 8'h00, 1'b0, bc, gd);
        check("s1_busy_cycles", 32'(bc), 32'd8);
        check("s1_sum",   32'(sum_o),   32'h00);
        check("s1_carry", 32'(carry_o), 32'd0);
        cycle();

        // 0xFF + 0x01 wraps, result held after done drops
        run_op(8'hFF, 8'h01, 1'b0, bc, gd);
        check("s2_sum",   32'(sum_o),   32'h00);
        check("s2_carry", 32'(carry_o), 32'd1);
        cycle();
        cycle();
        check("s2_done_low", 32'(done), 32'd0);
        check("s2_hold_carry", 32'(carry_o), 32'd1);

        // 0xA5 + 0x5A with spurious starts during RUN
        start = 1'b1; a = 8'hA5; b = 8'h5A; sub = 1'b0;
        cycle();
        ndone = 0;
        for (int i = 1; i <= int'(W) + 3; i++) begin
            start = (i >= 3 && i <= 5);
            if (start) begin a = 8'h11; b = 8'h11; end
            cycle();
            if (done) begin
                ndone++;
                check("s3_sum",   32'(sum_o),   32'hFF);
                check("s3_carry", 32'(carry_o), 32'd0);
            end
        end
        start = 1'b0;
        check("s3_single_done", 32'(ndone), 32'd1);

        // 0x80 + 0x80, then start in the done cycle
        run_op(8'h80, 8'h80, 1'b0, bc, gd);
        check("s4a_sum",   32'(sum_o),   32'h00);
        check("s4a_carry", 32'(carry_o), 32'd1);
        start = 1'b1; a = 8'h03; b = 8'h04;
        gap = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            start = 1'b0;
            gap++;
            if (done) break;
        end
        check("s4_gap", 32'(gap), 32'd9);
        check("s4b_sum",   32'(sum_o),   32'h07);
        check("s4b_carry", 32'(carry_o), 32'd0);

        // 0x7F + 0x7F aborted by reset mid-run
        start = 1'b1; a = 8'h7F; b = 8'h7F;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        reset = 1'b1;
        cycle();
        check("s5_busy",  32'(busy),    32'd0);
        check("s5_sum",   32'(sum_o),   32'h00);
        check("s5_carry", 32'(carry_o), 32'd0);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < int'(W) + 2; i++) begin
            cycle();
            if (done) ndone++;
        end
        check("s5_no_done", 32'(ndone), 32'd0);

`ifdef BIT_SERIAL_ADDER_SUB_EN
        run_op(8'h05, 8'h07, 1'b1, bc, gd);
        check("sub1_sum",   32'(sum_o),   32'hFE);
        check("sub1_carry", 32'(carry_o), 32'd0);
        cycle();
        run_op(8'h07, 8'h05, 1'b1, bc, gd);
        check("sub2_sum",   32'(sum_o),   32'h02);
        check("sub2_carry", 32'(carry_o), 32'd1);
        cycle();
`endif

        // Random traffic: random starts, operands, rare resets
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 2) == 0);
            a     = W'($urandom);
            b     = W'($urandom);
`ifdef BIT_SERIAL_ADDER_SUB_EN
            sub   = 1'($urandom);
`else
            sub   = 1'b0;
`endif
            reset = ($urandom_range(0, 199) == 0);
            cycle();
        end
        reset = 1'b0;
        start = 1'b0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
